div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Iterative restoring-division controller and datapath for the CPU's DIV/DIVU instructions.
- Accepts one operand pair and runs one shift-subtract step per clock.
- Applies sign correction, then presents quotient and remainder for the HI/LO write.
- Drives a stall line that holds the pipeline while the division is in flight.

Parameters:
- WIDTH, 32, operand, quotient and remainder width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- CLK  input  1  system clock; all registers update on the falling edge.
- RST_n  input  1  asynchronous reset, active-high despite the name. RST_n=1 clears all state immediately.
- start  input  1  request a division; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high in every state except IDLE.
- stall  output  1  combinational: busy | (start & state==IDLE).
- done  output  1  high for exactly one cycle, in state DONE.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_zero  output  1  divisor was 0 for the last accepted operation; held with the results.

Behaviour:
- Edge numbering: edge 0 is the falling edge that samples start=1 in IDLE.
- Reset (RST_n=1, asynchronous, any state):
  - state returns to IDLE; counter cleared.
  - quotient, remainder, div_zero, done and busy all 0.
  - Any in-flight operation is discarded; nothing completes later.
- States and transitions:
  - IDLE: on start=1 and divisor!=0, latch |dividend| and |divisor|, record the signs, clear the partial remainder and counter, go to RUN. With is_signed=0 the operands are latched as-is.
  - IDLE: on start=1 and divisor==0, go straight to DONE with quotient=all ones, remainder=dividend (raw, no sign processing), div_zero=1.
  - RUN: each edge performs one restoring step:
    - shift {rem,quo} left by 1;
    - trial = rem - divisor, computed at WIDTH+1 bits;
    - if non-negative, rem=trial and quotient LSB=1; otherwise restore rem and quotient LSB=0.
    - Counter increments; the step taken with counter==WIDTH-1 moves the state to FIX.
  - FIX (one edge):
    - negate the quotient if is_signed and the operand signs differ;
    - negate the remainder if is_signed and the dividend was negative;
    - go to DONE.
  - DONE: done=1 for one cycle, then IDLE on the next edge.
- Latency:
  - normal operation: RUN steps on edges 1..WIDTH, FIX step on edge WIDTH+1, done high between edges WIDTH+1 and WIDTH+2 (33..34 at WIDTH=32), IDLE after edge WIDTH+2;
  - divide-by-zero: done high between edges 0 and 1.
- start while busy (including in DONE) is ignored; operands are not re-latched and stall stays high.
- Signed overflow (most negative value / -1): quotient = 0x80000000, remainder = 0, div_zero=0. No trap.
- div_zero is cleared on the next accepted start that has a nonzero divisor.
- Outputs change only on a falling edge of CLK or on reset, except stall, which is combinational.

Test Plan:
- Reset, then DIVU 100/7 → busy=1 from edge 0, done=1 only between edges 33 and 34, quotient=14, remainder=2, div_zero=0; stall high from start until IDLE.
- DIV 0xFFFFFFF9 / 2 (i.e. -7/2) → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 7 / 0xFFFFFFFE (7/-2) → quotient=0xFFFFFFFD, remainder=1.
- DIVU 5/0 → done=1 immediately after edge 0, quotient=0xFFFFFFFF, remainder=5, div_zero=1, IDLE after edge 1; a following DIVU 9/3 → quotient=3, remainder=0, div_zero=0.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, no error flag.
- Start DIVU 1000/10, pulse start again with 50/5 at edge 5 → second request ignored; result is quotient=100, remainder=0 at the normal done cycle.
- Assert RST_n mid-RUN after edge 10 → busy, done, quotient and remainder drop to 0 immediately with no late done; after release, DIVU 81/9 completes with quotient=9, remainder=0.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: iterative restoring divider for DIV/DIVU.
// One shift-subtract step per falling clock edge, then a sign-fix step,
// then a one-cycle done pulse. Divide-by-zero short-circuits straight to DONE.
module div_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter value on which the final restoring step is taken.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             q_neg_q;
    logic             r_neg_q;

    logic             accept_c;
    logic             dvsr_zero_c;
    logic [WIDTH-1:0] dividend_abs_c;
    logic [WIDTH-1:0] divisor_abs_c;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH:0]   trial_c;
    logic             take_c;
    logic [WIDTH-1:0] rem_nx_c;
    logic [WIDTH-1:0] quo_nx_c;

    // Request qualification and operand magnitudes.
    always_comb begin
        accept_c       = (state_q == S_IDLE) && start;
        dvsr_zero_c    = (divisor == '0);
        dividend_abs_c = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_abs_c  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    // One restoring step: shift {rem,quo}, trial-subtract at WIDTH+1 bits.
    // Because rem < divisor, the trial's top bit is exactly its sign.
    always_comb begin
        rem_sh_c = {rem_q, quo_q[WIDTH-1]};
        trial_c  = rem_sh_c - {1'b0, dvsr_q};
        take_c   = ~trial_c[WIDTH];
        rem_nx_c = take_c ? trial_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
        quo_nx_c = {quo_q[WIDTH-2:0], take_c};
    end

    // State register.
    always_ff @(negedge CLK or posedge RST_n) begin
        if (RST_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = dvsr_zero_c ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered status flags, aligned with the state they describe.
    always_ff @(negedge CLK or posedge RST_n) begin
        if (RST_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= (state_d == S_DONE);
        end
    end

    // Working datapath: operand latch and iteration.
    always_ff @(negedge CLK or posedge RST_n) begin
        if (RST_n) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c && !dvsr_zero_c) begin
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= dividend_abs_c;
                        dvsr_q  <= divisor_abs_c;
                        q_neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_q <= is_signed && dividend[WIDTH-1];
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    rem_q <= rem_nx_c;
                    quo_q <= quo_nx_c;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: written at sign-fix or on a divide-by-zero request.
    always_ff @(negedge CLK or posedge RST_n) begin
        if (RST_n) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            if (accept_c) begin
                if (dvsr_zero_c) begin
                    quotient  <= '1;
                    remainder <= dividend;
                    div_zero  <= 1'b1;
                end else begin
                    div_zero  <= 1'b0;
                end
            end else if (state_q == S_FIX) begin
                quotient  <= q_neg_q ? -quo_q : quo_q;
                remainder <= r_neg_q ? -rem_q : rem_q;
            end
        end
    end

    // Pipeline hold: in flight, or a request is being accepted this cycle.
    always_comb begin
        stall = busy | (start & (state_q == S_IDLE));
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scoreboard of expected results,
// pushed at request time and popped when done is observed.
module tb_div_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = WIDTH + 1;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    exp_t sb[$];
    int   n_err = 0;
    int   n_checks = 0;

    div_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // Clock: DUT acts on falling edges; bench samples around rising edges.
    initial forever #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dz,
                                input int lat);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dz  = dz;
        e.lat = 8'(lat);
        return e;
    endfunction

    // Reference model using the language's truncating division.
    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        sa = a;
        sd = b;
        if (b == 32'd0)
            return mk(32'hFFFF_FFFF, a, 1'b1, 0);
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return mk(32'h8000_0000, 32'd0, 1'b0, LAT);
            return mk(32'(sa / sd), 32'(sa % sd), 1'b0, LAT);
        end
        return mk(a / b, a % b, 1'b0, LAT);
    endfunction

    // Issue one request, optionally inject an ignored start at edge inj,
    // then wait (bounded) for done and score the result.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int inj);
        exp_t got;
        int   k;
        int   stall_drops;
        sb.push_back(e);
        @(posedge CLK);
        start = 1'b1;
        is_signed = s;
        dividend = a;
        divisor = b;
        #1;
        check_eq("stall_req", 32'(stall), 32'd1);
        @(negedge CLK);
        @(posedge CLK);
        start = 1'b0;
        #1;
        check_eq("busy_e0", 32'(busy), 32'd1);
        k = 0;
        stall_drops = 0;
        while (!done && k < 40) begin
            if (!stall || !busy) stall_drops++;
            @(negedge CLK);
            k++;
            @(posedge CLK);
            start = (k == inj - 1);
            if (start) begin
                is_signed = 1'b0;
                dividend = 32'd50;
                divisor = 32'd5;
            end
            #1;
            if (start) check_eq("stall_busy", 32'(stall), 32'd1);
        end
        if (!done) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end else if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check_eq("latency", 32'(k), 32'(got.lat));
            check_eq("quotient", quotient, got.q);
            check_eq("remainder", remainder, got.r);
            check_eq("div_zero", 32'(div_zero), 32'(got.dz));
            check_eq("stall_held", 32'(stall_drops), 32'd0);
        end
        start = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_stall", 32'(stall), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int late;
        logic s;
        logic [31:0] a;
        logic [31:0] b;

        #2 RST_n = 1'b1;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_quotient", quotient, 32'd0);
        check_eq("rst_remainder", remainder, 32'd0);
        check_eq("rst_div_zero", 32'(div_zero), 32'd0);
        repeat (3) @(posedge CLK);
        RST_n = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, LAT), -1);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT), -1);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, mk(32'hFFFF_FFFD, 32'd1, 1'b0, LAT), -1);
        run_op(1'b0, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1, 0), -1);
        run_op(1'b0, 32'd9, 32'd3, mk(32'd3, 32'd0, 1'b0, LAT), -1);
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, mk(32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0), -1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b0, LAT), -1);
        run_op(1'b0, 32'd1000, 32'd10, mk(32'd100, 32'd0, 1'b0, LAT), 5);

        // Reset mid-RUN after edge 10: everything drops, nothing completes later.
        @(posedge CLK);
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd1000;
        divisor = 32'd10;
        @(negedge CLK);
        @(posedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        @(posedge CLK);
        RST_n = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_quotient", quotient, 32'd0);
        check_eq("midrst_remainder", remainder, 32'd0);
        check_eq("midrst_stall", 32'(stall), 32'd0);
        repeat (2) @(posedge CLK);
        RST_n = 1'b0;
        late = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (done || busy) late++;
        end
        check_eq("no_late_done", 32'(late), 32'd0);
        run_op(1'b0, 32'd81, 32'd9, mk(32'd9, 32'd0, 1'b0, LAT), -1);

        // Randomised operands scored against the reference model.
        for (int i = 0; i < 10; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 1000));
            if (i % 4 == 3)
                b = 32'd0;
            else if ($urandom_range(0, 1) != 0)
                b = 32'($urandom);
            else
                b = 32'($urandom_range(1, 20));
            run_op(s, a, b, model(s, a, b), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
